// File: rtl/psram_ram_arb.sv
// Two-master arbiter for the shared system RAM req/ack port: grants one master
// at a time, registers the RAM request, steers acks to the owner, and aborts stuck accesses.
module psram_ram_arb #(
  parameter int AW         = 17,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic          hclk,
  input  logic          hrstn,
  input  logic          m0_wr_req,
  input  logic          m0_rd_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_wr_ack,
  output logic          m0_rd_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_wr_req,
  input  logic          m1_rd_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_wr_ack,
  output logic          m1_rd_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_wr_req,
  output logic          ram_rd_req,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic          ram_wr_ack,
  input  logic          ram_rd_ack,
  input  logic [DW-1:0] ram_rdata,
  output logic          owner,
  output logic          busy,
  output logic          err_timeout,
  input  logic          err_clr,
  output logic [1:0]    state_dbg
);

  // Handshake: a master holds wr_req/rd_req until it sees the matching one-cycle
  // ack and drops the request on that same edge; the RAM side works the same way
  // with ram_*_req held until ram_*_ack.

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, TOUT = 2'd2} state_t;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state, state_nxt;
  logic          op_wr;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tcnt;
  logic          m0_any, m1_any, grant_m1, grant_wr;
  logic          ack_hit, tout_hit, wr_done, rd_done;
  logic [DW-1:0] rsp_data;

  always_comb begin
    m0_any    = m0_wr_req | m0_rd_req;
    m1_any    = m1_wr_req | m1_rd_req;
    grant_m1  = m1_any & (~m0_any | (starve_cnt == SW'(STARVE_MAX)));
    grant_wr  = grant_m1 ? m1_wr_req : m0_wr_req;
    ack_hit   = op_wr ? ram_wr_ack : ram_rd_ack;
    tout_hit  = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));
    state_nxt = state;
    wr_done   = 1'b0;
    rd_done   = 1'b0;
    case (state)
      IDLE: if (m0_any | m1_any) state_nxt = BUSY;
      BUSY: begin
        if (ack_hit) begin
          state_nxt = IDLE;
          wr_done   = op_wr;
          rd_done   = ~op_wr;
        end else if (tout_hit) begin
          state_nxt = TOUT;
        end
      end
      TOUT: begin
        state_nxt = IDLE;
        wr_done   = op_wr;
        rd_done   = ~op_wr;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      state       <= IDLE;
      op_wr       <= 1'b0;
      owner       <= 1'b0;
      ram_wr_req  <= 1'b0;
      ram_rd_req  <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      starve_cnt  <= '0;
      tcnt        <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (m0_any | m1_any) begin
            owner      <= grant_m1;
            op_wr      <= grant_wr;
            ram_wr_req <= grant_wr;
            ram_rd_req <= ~grant_wr;
            ram_addr   <= grant_m1 ? m1_addr : m0_addr;
            ram_wdata  <= grant_m1 ? m1_wdata : m0_wdata;
          end
          // m1 pending and not granted means m0 took this slot
          if (!m1_any || grant_m1) starve_cnt <= '0;
          else                     starve_cnt <= starve_cnt + SW'(1);
        end
        BUSY: begin
          if (ack_hit || tout_hit) begin
            ram_wr_req <= 1'b0;
            ram_rd_req <= 1'b0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: ;
      endcase
      if (state == BUSY && !ack_hit && tout_hit) err_timeout <= 1'b1;
      else if (err_clr)                          err_timeout <= 1'b0;
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign rsp_data  = (state == TOUT) ? DW'(32'hDEAD_BEEF) : ram_rdata;
  assign m0_wr_ack = wr_done & ~owner;
  assign m1_wr_ack = wr_done & owner;
  assign m0_rd_ack = rd_done & ~owner;
  assign m1_rd_ack = rd_done & owner;
  assign m0_rdata  = m0_rd_ack ? rsp_data : '0;
  assign m1_rdata  = m1_rd_ack ? rsp_data : '0;

endmodule

// File: tb/tb_psram_ram_arb.sv
// Bench for psram_ram_arb: directed timing steps plus random two-master traffic
// checked against a word-level memory model and expected grant orders.
module tb_psram_ram_arb;

  logic        hclk, hrstn;
  logic        m0_wr_req, m0_rd_req, m1_wr_req, m1_rd_req;
  logic [16:0] m0_addr, m1_addr, ram_addr;
  logic [31:0] m0_wdata, m1_wdata, ram_wdata, m0_rdata, m1_rdata, ram_rdata;
  logic        m0_wr_ack, m0_rd_ack, m1_wr_ack, m1_rd_ack;
  logic        ram_wr_req, ram_rd_req, ram_wr_ack, ram_rd_ack;
  logic        owner, busy, err_timeout, err_clr;
  logic [1:0]  state_dbg;

  psram_ram_arb #(.AW(17), .DW(32), .STARVE_MAX(4), .TIMEOUT(16)) dut (
    .hclk(hclk), .hrstn(hrstn),
    .m0_wr_req(m0_wr_req), .m0_rd_req(m0_rd_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wr_ack(m0_wr_ack), .m0_rd_ack(m0_rd_ack), .m0_rdata(m0_rdata),
    .m1_wr_req(m1_wr_req), .m1_rd_req(m1_rd_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wr_ack(m1_wr_ack), .m1_rd_ack(m1_rd_ack), .m1_rdata(m1_rdata),
    .ram_wr_req(ram_wr_req), .ram_rd_req(ram_rd_req), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wr_ack(ram_wr_ack), .ram_rd_ack(ram_rd_ack), .ram_rdata(ram_rdata),
    .owner(owner), .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr),
    .state_dbg(state_dbg)
  );

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;

  // clock / reset / watchdog
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;
  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete, vectors=%0d", n_vec);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // memory reference model and RAM responder
  logic [31:0] ref_mem [logic [16:0]];
  logic [31:0] ram_mem [logic [16:0]];
  bit ram_mute = 0;
  bit force_rd_ack = 0;
  int ram_lat = 1;
  int ram_wait = 0;
  int cur_lat = 1;

  function automatic logic [31:0] init_word(input logic [16:0] a);
    return {15'h0, a} ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [16:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  always @(posedge hclk) begin
    #1;
    if (ram_mute) begin
      ram_wr_ack = 1'b0;
      ram_rd_ack = force_rd_ack;
      ram_wait   = 0;
    end else if (ram_wr_ack || ram_rd_ack) begin
      ram_wr_ack = 1'b0;
      ram_rd_ack = 1'b0;
      ram_rdata  = $urandom;
      ram_wait   = 0;
    end else if (ram_wr_req || ram_rd_req) begin
      if (ram_wait == 0) cur_lat = (ram_lat == 0) ? $urandom_range(1, 4) : ram_lat;
      ram_wait++;
      if (ram_wait >= cur_lat) begin
        if (ram_wr_req) begin
          ram_mem[ram_addr] = ram_wdata;
          ram_wr_ack = 1'b1;
        end else begin
          ram_rdata  = ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : init_word(ram_addr);
          ram_rd_ack = 1'b1;
        end
      end
    end else begin
      ram_wait = 0;
    end
  end

  // grant log and per-cycle ack steering checks
  typedef struct { logic own; int c; } grant_t;
  grant_t glog[$];
  logic prev_req = 1'b0;

  always @(negedge hclk) begin
    if ((ram_wr_req | ram_rd_req) && !prev_req) glog.push_back('{owner, cyc});
    prev_req = ram_wr_req | ram_rd_req;
    chk("m0_ack_without_req", {m0_wr_ack & ~m0_wr_req, m0_rd_ack & ~m0_rd_req}, 0);
    chk("m1_ack_without_req", {m1_wr_ack & ~m1_wr_req, m1_rd_ack & ~m1_rd_req}, 0);
    chk("ack_both_masters", (m0_wr_ack | m0_rd_ack) & (m1_wr_ack | m1_rd_ack), 0);
    chk("rdata_leak", {m0_rd_ack ? 32'h0 : m0_rdata, m1_rd_ack ? 32'h0 : m1_rdata}, 0);
  end

  // master driver tasks
  task automatic drive_m(input int m, input bit w, input bit r,
                         input logic [16:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_wr_req = w; m0_rd_req = r; m0_addr = a; m0_wdata = d;
    end else begin
      m1_wr_req = w; m1_rd_req = r; m1_addr = a; m1_wdata = d;
    end
  endtask

  // Call at posedge+1; returns at posedge+1 after the last ack edge.
  task automatic m_access(input int m, input bit w, input bit r, input logic [16:0] a,
                          input logic [31:0] d, output int ack_cyc);
    bit pw, pr, wa, ra;
    logic [31:0] rd;
    int g;
    pw = w; pr = r; g = 0; ack_cyc = -1;
    drive_m(m, pw, pr, a, d);
    while ((pw || pr) && g < 200) begin
      @(negedge hclk);
      g++;
      wa = (m == 0) ? m0_wr_ack : m1_wr_ack;
      ra = (m == 0) ? m0_rd_ack : m1_rd_ack;
      rd = (m == 0) ? m0_rdata : m1_rdata;
      if (wa || ra) begin
        ack_cyc = cyc;
        chk("wr_rd_ack_same_cycle", wa & ra, 0);
        if (wa) begin
          chk("unexpected_wr_ack", pw, 1);
          ref_mem[a] = d;
          pw = 0;
        end else begin
          chk("rd_before_wr", pw, 0);
          chk("unexpected_rd_ack", pr, 1);
          chk("rdata", rd, ref_rd(a));
          pr = 0;
        end
        @(posedge hclk); #1;
        if (pw || pr) drive_m(m, pw, pr, a, d);
        else          drive_m(m, 0, 0, 17'($urandom), $urandom);
      end
    end
    chk("access_completed", pw | pr, 0);
    if (pw || pr) begin
      drive_m(m, 0, 0, a, d);
      @(posedge hclk); #1;
    end
  endtask

  int hi, s, c0, c1, ca, cb;
  bit got;
  logic [31:0] got_data;
  logic exp_own[7] = '{0, 0, 0, 0, 1, 0, 0};

  initial begin
    hrstn = 1'b0; err_clr = 1'b0;
    m0_wr_req = 0; m0_rd_req = 0; m0_addr = '0; m0_wdata = '0;
    m1_wr_req = 0; m1_rd_req = 0; m1_addr = '0; m1_wdata = '0;
    ram_wr_ack = 0; ram_rd_ack = 0; ram_rdata = 32'h1234_5678;

    // reset values
    repeat (2) @(negedge hclk);
    chk("rst_ram_req", {ram_wr_req, ram_rd_req}, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_owner_busy_err", {owner, busy, err_timeout}, 0);
    chk("rst_acks", {m0_wr_ack, m0_rd_ack, m1_wr_ack, m1_rd_ack}, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    @(posedge hclk); #1 hrstn = 1'b1;

    // T1: m1 write, RAM acks in the second BUSY cycle
    ram_lat = 2;
    @(posedge hclk); #1;
    drive_m(1, 1, 0, 17'h10000, 32'h000C_08E0);
    @(negedge hclk);
    chk("t1_req_not_yet", ram_wr_req, 0);
    @(negedge hclk);
    chk("t1_ram_wr_req", {ram_wr_req, ram_rd_req}, 2'b10);
    chk("t1_ram_addr", ram_addr, 17'h10000);
    chk("t1_ram_wdata", ram_wdata, 32'h000C_08E0);
    chk("t1_owner_busy", {owner, busy}, 2'b11);
    @(negedge hclk);
    chk("t1_m1_wr_ack", m1_wr_ack, 1);
    chk("t1_m0_acks", {m0_wr_ack, m0_rd_ack}, 0);
    ref_mem[17'h10000] = 32'h000C_08E0;
    @(posedge hclk); #1;
    drive_m(1, 0, 0, 17'h0ABCD, 32'hFFFF_FFFF);
    @(negedge hclk);
    chk("t1_done", {m1_wr_ack, ram_wr_req, busy}, 0);

    // T2: simultaneous m0 read and m1 write
    ram_mem[17'h00100] = 32'h5555_AAAA;
    ref_mem[17'h00100] = 32'h5555_AAAA;
    ram_lat = 1;
    @(posedge hclk); #1;
    glog.delete();
    s = cyc;
    fork
      m_access(0, 0, 1, 17'h00100, 32'h0, c0);
      m_access(1, 1, 0, 17'h10001, 32'h1357_9BDF, c1);
    join
    chk("t2_grants", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("t2_first_owner", glog[0].own, 0);
      chk("t2_first_latency", glog[0].c, s + 1);
      chk("t2_second_owner", glog[1].own, 1);
      chk("t2_m1_after_m0_ack", glog[1].c, c0 + 2);
    end

    // T3: m0 back-to-back reads starve m1 for exactly four grants
    ram_lat = 0;
    @(posedge hclk); #1;
    glog.delete();
    fork
      for (int i = 0; i < 6; i++) m_access(0, 0, 1, 17'(i + 8), 32'h0, ca);
      m_access(1, 1, 0, 17'h00040, 32'hCAFE_0040, cb);
    join
    chk("t3_grants", glog.size(), 7);
    for (int i = 0; i < 7 && i < glog.size(); i++) chk("t3_owner_order", glog[i].own, exp_own[i]);

    // T4: RAM never acks, read aborts after 16 BUSY cycles
    ram_mute = 1;
    @(posedge hclk); #1;
    drive_m(0, 0, 1, 17'h00300, 32'h0);
    hi = 0; got = 0; got_data = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge hclk);
      if (m0_rd_ack) begin
        got = 1;
        got_data = m0_rdata;
        chk("t4_tout_busy", {busy, ram_rd_req, err_timeout}, 3'b101);
      end else if (ram_rd_req) begin
        hi++;
      end
    end
    chk("t4_ack_seen", got, 1);
    chk("t4_busy_cycles", hi, 16);
    chk("t4_deadbeef", got_data, 32'hDEAD_BEEF);
    @(posedge hclk); #1;
    drive_m(0, 0, 0, 17'h00300, 32'h0);
    @(negedge hclk);
    chk("t4_ack_single_pulse", m0_rd_ack, 0);
    force_rd_ack = 1;
    @(negedge hclk);
    force_rd_ack = 0;
    chk("t4_late_ack_ignored", {m0_rd_ack, m1_rd_ack, busy}, 0);
    @(negedge hclk);
    chk("t4_idle_after_late", {busy, ram_rd_req}, 0);
    chk("t4_err_sticky", err_timeout, 1);
    @(posedge hclk); #1 err_clr = 1'b1;
    @(posedge hclk); #1 err_clr = 1'b0;
    @(negedge hclk);
    chk("t4_err_cleared", err_timeout, 0);

    // T5: reset during a stuck m1 access
    @(posedge hclk); #1;
    drive_m(1, 1, 0, 17'h00155, 32'h0155_0155);
    repeat (3) @(negedge hclk);
    chk("t5_busy_before", {busy, owner, ram_wr_req}, 3'b111);
    #2 hrstn = 1'b0;
    #1;
    chk("t5_async_outputs", {busy, owner, ram_wr_req, ram_rd_req, err_timeout}, 0);
    chk("t5_async_addr_data", {ram_addr, ram_wdata}, 0);
    drive_m(1, 0, 0, 17'h0, 32'h0);
    @(posedge hclk); #1 hrstn = 1'b1;
    ram_mute = 0;
    ram_lat = 1;
    @(posedge hclk); #1;
    glog.delete();
    s = cyc;
    m_access(1, 1, 0, 17'h00156, 32'h0156_0156, c1);
    chk("t5_regrant", glog.size(), 1);
    if (glog.size() == 1) chk("t5_regrant_latency", {glog[0].own, 31'(glog[0].c)}, {1'b1, 31'(s + 1)});

    // T6: m1 write+read to one address, write first
    ram_lat = 2;
    m_access(1, 1, 1, 17'h00200, 32'h0200_BEEF, c1);

    // random two-master traffic
    ram_lat = 0;
    fork
      for (int i = 0; i < 25; i++) begin
        int op;
        op = $urandom_range(0, 2);
        m_access(0, op != 1, op != 0,
                 ($urandom_range(0, 6) == 6) ? 17'h1FFFF : 17'($urandom_range(0, 5)), $urandom, ca);
        repeat ($urandom_range(0, 2)) begin @(posedge hclk); #1; end
      end
      for (int j = 0; j < 25; j++) begin
        int op;
        op = $urandom_range(0, 2);
        m_access(1, op != 1, op != 0,
                 ($urandom_range(0, 6) == 6) ? 17'h1FFFF : 17'($urandom_range(0, 5)), $urandom, cb);
        repeat ($urandom_range(0, 2)) begin @(posedge hclk); #1; end
      end
    join
    @(negedge hclk);
    chk("final_idle", {busy, ram_wr_req, ram_rd_req, err_timeout}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
